// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial add/subtract front end.
// No logic: state encoding and operation select codes only.
// No handshake; consumed by serial_addsub_driver and its testbench.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_bit_alu.sv
// Single-bit full adder with a loadable carry flip-flop (init, enable).
// Sum and cout are combinational; the carry updates one cycle after en.
// No flow control; the driver FSM sequences load and en.
module serial_bit_alu (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic init,
    input  logic en,
    input  logic x,
    input  logic y,
    output logic sum,
    output logic cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic carry_msb_in
`endif
);

    logic carry;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            carry <= 1'b0;
        else if (load)
            carry <= init;
        else if (en)
            carry <= cout;
    end

    assign sum  = x ^ y ^ carry;
    assign cout = (x & y) | (x & carry) | (y & carry);

`ifdef SERIAL_ADDSUB_OVF_EN
    // On the MSB step this is the carry into the MSB.
    assign carry_msb_in = carry;
`endif

endmodule

// File: rtl/serial_addsub_driver.sv
// Parallel-in/out bit-serial adder/subtractor; optional overflow flag via SERIAL_ADDSUB_OVF_EN.
// Latency: start-to-done = WIDTH+1 cycles; back-to-back period WIDTH+2.
// No backpressure: start is only sampled in IDLE, starts while busy are dropped.
module serial_addsub_driver
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic             overflow,
`endif
    output logic             ser_x,
    output logic             ser_y,
    output logic             ser_s
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_reg, b_reg, acc;
    logic               sub_reg;
    logic [CNT_W-1:0]   count;
    logic               accept, shift_en, last;
    logic               cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               carry_msb_in;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        shift_en  = 1'b0;
        last      = (count == CNT_W'(WIDTH - 1));
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ser_x = a_reg[0];
    assign ser_y = b_reg[0] ^ (sub_reg == OP_SUB);

    serial_bit_alu u_alu (
        .clock        (clock),
        .reset        (reset),
        .load         (accept),
        .init         (op_sub),
        .en           (shift_en),
        .x            (ser_x),
        .y            (ser_y),
        .sum          (ser_s),
        .cout         (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .carry_msb_in (carry_msb_in)
`endif
    );

    // result/carry_out are loaded on the final shift so they are valid while done is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            sub_reg   <= 1'b0;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            overflow  <= 1'b0;
`endif
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= op_sub;
            count   <= '0;
        end else if (shift_en) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            acc   <= {ser_s, acc[WIDTH-1:1]};
            count <= count + CNT_W'(1);
            if (last) begin
                result    <= {ser_s, acc[WIDTH-1:1]};
                carry_out <= cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                overflow  <= carry_msb_in ^ cout;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_driver.sv
// Directed bench for serial_addsub_driver with an arithmetic reference model.
// Model predicts per-cycle busy/done/taps/result; literal vectors pin the model.
module tb_serial_addsub_driver;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out, ser_x, ser_y, ser_s;
    logic [W-1:0] result;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         overflow;
`endif

    serial_addsub_driver #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
`ifdef SERIAL_ADDSUB_OVF_EN
        .overflow  (overflow),
`endif
        .ser_x     (ser_x),
        .ser_y     (ser_y),
        .ser_s     (ser_s)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1..W shifting bit phase-1, W+1 done.
    int           ph = 0;
    logic [W-1:0] ma = '0, mb = '0, beff = '0;
    logic         ms = 1'b0;
    logic [W:0]   mfull = '0;
    logic [W-1:0] mres = '0;
    logic         mc = 1'b0, movf = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ph = 0; mres = '0; mc = 1'b0; movf = 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ma = a; mb = b; ms = op_sub;
                beff = op_sub ? ~b : b;
                mfull = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, op_sub};
                ph = 1;
            end
        end else if (ph <= W) begin
            if (ph == W) begin
                mres = mfull[W-1:0];
                mc   = mfull[W];
                movf = (ma[W-1] == beff[W-1]) && (mres[W-1] != ma[W-1]);
            end
            ph++;
        end else begin
            ph = 0;
        end
    end

    logic [W-1:0] s_cap = '0;
    int           done_cnt = 0;

    always @(negedge clock) begin
        chk("busy", busy, (ph >= 1 && ph <= W));
        chk("done", done, (ph == W + 1));
        chk("result", result, mres);
        chk("carry_out", carry_out, mc);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("overflow", overflow, movf);
`endif
        if (ph >= 1 && ph <= W) begin
            chk("ser_x", ser_x, ma[ph-1]);
            chk("ser_y", ser_y, mb[ph-1] ^ ms);
            chk("ser_s", ser_s, mfull[ph-1]);
            s_cap = {ser_s, s_cap[W-1:1]};
        end
        if (done) done_cnt++;
    end

    task automatic wait_done(input string nm, output int lat);
        lat = 1;
        @(negedge clock);
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic isub, input logic [W-1:0] er, input logic ec, input logic eo);
        int lat;
        @(negedge clock);
        a = ia; b = ib; op_sub = isub; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk({nm, "_latency"}, lat, 9);
        chk({nm, "_result"}, result, er);
        chk({nm, "_carry"}, carry_out, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk({nm, "_ovf"}, overflow, eo);
`else
        if (eo === 1'bx) $display("note: unexpected x in overflow vector");
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, lat, last, pulses;
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry_out, 0);
        #2 reset = 1'b0;

        run_op("add_7f", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        chk("add_7f_serial_s", s_cap, 8'h7F);
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_nb", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
        run_op("sub_borrow", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0);

        // Start pulse during busy must be ignored.
        @(negedge clock);
        dc = done_cnt;
        a = 8'h35; b = 8'h4A; op_sub = 1'b0; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        a = 8'h00; b = 8'h00; start = 1'b1;
        @(negedge clock); start = 1'b0;
        wait_done("busy_start", lat);
        chk("busy_start_result", result, 8'h7F);
        repeat (4) @(negedge clock);
        chk("busy_start_pulses", done_cnt - dc, 1);

        // Reset mid-operation aborts with no done pulse.
        @(negedge clock);
        a = 8'h12; b = 8'h34; op_sub = 1'b0; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (3) @(negedge clock);
        dc = done_cnt;
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_done", done, 0);
        @(negedge clock);
        #2 reset = 1'b0;
        repeat (12) @(negedge clock);
        chk("midrst_no_done", done_cnt - dc, 0);
        run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Start held high: one result every WIDTH+2 cycles.
        @(negedge clock);
        a = 8'h01; b = 8'h01; op_sub = 1'b0; start = 1'b1;
        last = -1; pulses = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            if (done) begin
                chk("b2b_result", result, 8'h02);
                if (last >= 0) chk("b2b_period", i - last, 10);
                last = i;
                pulses++;
            end
        end
        chk("b2b_pulses", pulses, 3);
        start = 1'b0;
        repeat (14) @(negedge clock);
        chk("end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
